alu_arbiter_2ch: RTL

Two-channel round-robin arbiter and sequencer that shares one clocked 4-bit ALU between two requesters. It accepts operation requests through valid/ready handshakes and drives the operands and select lines to the ALU. It waits a fixed ALU latency, captures the result and flags, and returns them on the granted channel's response handshake. It sits between the request sources (CPU front-end, test sequencer) and the single ALU instance.

---
 rtl/alu_arbiter_2ch.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter_2ch.sv
// alu_arbiter_2ch: two-channel round-robin arbiter/sequencer in front of one
// shared clocked 4-bit ALU. Accepts one request at a time, holds the ALU
// operands for ALU_LAT cycles, captures result/flags and returns them on the
// granted channel's response handshake.
// Optional feature macro: FLAG_RECOMPUTE_EN -- when defined, Z and N are
// derived from the captured alu_out instead of the ALU's own flag outputs.
module alu_arbiter_2ch #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [3:0]       req0_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [3:0]       rsp0_data,
  output logic [3:0]       rsp0_flags,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [3:0]       req1_sel,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [3:0]       rsp1_data,
  output logic [3:0]       rsp1_flags,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [3:0]       alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [2:0] LAT_L = 3'(ALU_LAT);

  state_t     state;
  logic       last_grant;
  logic       owner;
  logic [2:0] cnt;
  logic       grant;
  logic       rsp_hs;
  logic [3:0] cap_flags;

  // Round-robin choice: a lone valid channel wins, a tie goes to the channel not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state == ST_IDLE) && !grant && req0_valid;
  assign req1_ready = (state == ST_IDLE) &&  grant && req1_valid;
  assign busy       = (state != ST_IDLE);

  // Response handshake of whichever channel owns the current operation.
  always_comb begin
    rsp_hs = owner ? rsp1_ready : rsp0_ready;
  end

`ifdef FLAG_RECOMPUTE_EN
  logic unused_alu_flags;
  assign unused_alu_flags = alu_zero ^ alu_neg;

  // Flags {C,Z,N,V}; Z and N re-derived from the result itself.
  always_comb begin
    cap_flags = {alu_carry, (alu_out == 4'd0), alu_out[3], alu_ovf};
  end
`else
  // Flags {C,Z,N,V} passed straight through from the ALU.
  always_comb begin
    cap_flags = {alu_carry, alu_zero, alu_neg, alu_ovf};
  end
`endif

  // Sequencer: accept in IDLE, count out the ALU latency in WAIT, hold the response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_flags <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_flags <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0_ready || req1_ready) begin
            alu_a      <= grant ? req1_a   : req0_a;
            alu_b      <= grant ? req1_b   : req0_b;
            alu_sel    <= grant ? req1_sel : req0_sel;
            owner      <= grant;
            last_grant <= grant;
            cnt        <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 3'd1;
          if (cnt == LAT_L) begin
            if (owner) begin
              rsp1_valid <= 1'b1;
              rsp1_data  <= alu_out;
              rsp1_flags <= cap_flags;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_data  <= alu_out;
              rsp0_flags <= cap_flags;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            op_count   <= op_count + CNT_W'(1);
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
